// File: rtl/regfile_writeback_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback_scheduler_pkg: shared types/constants, rev 1.0      |
// +----------------------------------------------------------------------+
package regfile_writeback_scheduler_pkg;

   localparam int LONG_MAX          = 4;
   localparam int STARVE_LIMIT      = 3;
   localparam int OUTSTANDING_WIDTH = 3;

   typedef struct packed {
      logic [4:0]  rd_address;
      logic [31:0] data;
   } writeback_request_t;

   function automatic logic [31:0] reg_onehot(input logic [4:0] address);
      return 32'd1 << address;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_scheduler_register_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_scoreboard: busy map, long-op counter, issue stall, rev 1.0  |
// +----------------------------------------------------------------------+
module register_scoreboard #(
   parameter int LONG_MAX = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_long,
   input  logic [4:0]  issue_rs1_address,
   input  logic [4:0]  issue_rs2_address,
   input  logic [4:0]  issue_rd_address,
   input  logic        long_accept,
   input  logic [4:0]  long_rd_address,
   output logic        issue_stall,
   output logic [31:0] busy_map,
   output logic [2:0]  outstanding
);
   import regfile_writeback_scheduler_pkg::*;

   localparam logic [2:0] LONG_MAX_COUNT = 3'(LONG_MAX);

   logic [31:0] busy_map_q, busy_map_d;
   logic [2:0]  outstanding_q, outstanding_d;
   logic        rs1_busy, rs2_busy, rd_busy, long_full;
   logic        issue_accept, long_issue, long_retire;

   always_comb begin
      rs1_busy  = (issue_rs1_address != 5'd0) && busy_map_q[issue_rs1_address];
      rs2_busy  = (issue_rs2_address != 5'd0) && busy_map_q[issue_rs2_address];
      rd_busy   = (issue_rd_address  != 5'd0) && busy_map_q[issue_rd_address];
      long_full = issue_long && (outstanding_q == LONG_MAX_COUNT);

      issue_stall  = issue_valid && (rs1_busy || rs2_busy || rd_busy || long_full);
      issue_accept = issue_valid && !issue_stall;
      long_issue   = issue_accept && issue_long;
      // A retire with nothing outstanding is a protocol error; the count floors at 0.
      long_retire  = long_accept && (outstanding_q != 3'd0);
   end

   always_comb begin
      busy_map_d = busy_map_q;
      if (long_accept) begin
         busy_map_d = busy_map_d & ~reg_onehot(long_rd_address);
      end
      // Applied after the clear so a same-cycle set wins.
      if (long_issue) begin
         busy_map_d = busy_map_d | reg_onehot(issue_rd_address);
      end
      busy_map_d[0] = 1'b0;
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (long_issue && !long_retire && (outstanding_q != LONG_MAX_COUNT)) begin
         outstanding_d = outstanding_q + 3'd1;
      end else if (long_retire && !long_issue) begin
         outstanding_d = outstanding_q - 3'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_map_q    <= 32'd0;
         outstanding_q <= 3'd0;
      end else begin
         busy_map_q    <= busy_map_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign busy_map    = busy_map_q;
   assign outstanding = outstanding_q;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback_scheduler: short/long write-back arbiter, rev 1.0   |
// +----------------------------------------------------------------------+
module regfile_writeback_scheduler #(
   parameter int LONG_MAX     = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_long,
   input  logic [4:0]  issue_rs1_address,
   input  logic [4:0]  issue_rs2_address,
   input  logic [4:0]  issue_rd_address,
   output logic        issue_stall,
   input  logic        short_valid,
   input  logic [4:0]  short_rd_address,
   input  logic [31:0] short_data,
   output logic        short_ready,
   input  logic        long_valid,
   input  logic [4:0]  long_rd_address,
   input  logic [31:0] long_data,
   output logic        long_ready,
   output logic [4:0]  rf_rd_address,
   output logic [31:0] rf_write_data,
   output logic        rf_write_enable,
   output logic [31:0] busy_map
);
   import regfile_writeback_scheduler_pkg::*;

   localparam int                      STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_WIDTH-1:0] STARVE_MAX   = STARVE_WIDTH'(STARVE_LIMIT);

   logic [STARVE_WIDTH-1:0] starve_q, starve_d;
   writeback_request_t      writeback_q, writeback_d;
   logic                    write_enable_q, write_enable_d;
   logic                    force_long;
   logic                    short_accept, long_accept;
   logic [2:0]              outstanding;

   always_comb begin
      force_long   = (starve_q == STARVE_MAX);
      short_ready  = short_valid && !force_long;
      long_ready   = long_valid && (!short_valid || force_long);
      short_accept = short_valid && short_ready;
      long_accept  = long_valid && long_ready;
   end

   always_comb begin
      starve_d = starve_q;
      if (!long_valid || long_ready) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Arbitration guarantees at most one of the two accepts per cycle.
   always_comb begin
      writeback_d    = writeback_q;
      write_enable_d = 1'b0;
      if (short_accept) begin
         writeback_d.rd_address = short_rd_address;
         writeback_d.data       = short_data;
         write_enable_d         = (short_rd_address != 5'd0);
      end else if (long_accept) begin
         writeback_d.rd_address = long_rd_address;
         writeback_d.data       = long_data;
         write_enable_d         = (long_rd_address != 5'd0);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_q       <= '0;
         writeback_q    <= '0;
         write_enable_q <= 1'b0;
      end else begin
         starve_q       <= starve_d;
         writeback_q    <= writeback_d;
         write_enable_q <= write_enable_d;
      end
   end

   assign rf_rd_address   = writeback_q.rd_address;
   assign rf_write_data   = writeback_q.data;
   assign rf_write_enable = write_enable_q;

   register_scoreboard #(
      .LONG_MAX (LONG_MAX)
   ) u_scoreboard (
      .clock             (clock),
      .reset             (reset),
      .issue_valid       (issue_valid),
      .issue_long        (issue_long),
      .issue_rs1_address (issue_rs1_address),
      .issue_rs2_address (issue_rs2_address),
      .issue_rd_address  (issue_rd_address),
      .long_accept       (long_accept),
      .long_rd_address   (long_rd_address),
      .issue_stall       (issue_stall),
      .busy_map          (busy_map),
      .outstanding       (outstanding)
   );

   // The count is kept for observation only; the stall logic consumes it internally.
   logic unused_outstanding;
   assign unused_outstanding = ^outstanding;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_writeback_scheduler: directed scoreboard bench, rev 1.0    |
// +----------------------------------------------------------------------+
module tb_regfile_writeback_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid, issue_long;
   logic [4:0]  issue_rs1_address, issue_rs2_address, issue_rd_address;
   logic        issue_stall;
   logic        short_valid;
   logic [4:0]  short_rd_address;
   logic [31:0] short_data;
   logic        short_ready;
   logic        long_valid;
   logic [4:0]  long_rd_address;
   logic [31:0] long_data;
   logic        long_ready;
   logic [4:0]  rf_rd_address;
   logic [31:0] rf_write_data;
   logic        rf_write_enable;
   logic [31:0] busy_map;

   int compared   = 0;
   int mismatched = 0;
   logic [36:0] expected_q[$];

   regfile_writeback_scheduler dut (
      .clock             (clock),
      .reset             (reset),
      .issue_valid       (issue_valid),
      .issue_long        (issue_long),
      .issue_rs1_address (issue_rs1_address),
      .issue_rs2_address (issue_rs2_address),
      .issue_rd_address  (issue_rd_address),
      .issue_stall       (issue_stall),
      .short_valid       (short_valid),
      .short_rd_address  (short_rd_address),
      .short_data        (short_data),
      .short_ready       (short_ready),
      .long_valid        (long_valid),
      .long_rd_address   (long_rd_address),
      .long_data         (long_data),
      .long_ready        (long_ready),
      .rf_rd_address     (rf_rd_address),
      .rf_write_data     (rf_write_data),
      .rf_write_enable   (rf_write_enable),
      .busy_map          (busy_map)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      issue_valid = 0; issue_long = 0;
      issue_rs1_address = 0; issue_rs2_address = 0; issue_rd_address = 0;
      short_valid = 0; short_rd_address = 0; short_data = 0;
      long_valid = 0; long_rd_address = 0; long_data = 0;
   endtask

   task automatic issue(input logic is_long, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd);
      issue_valid = 1; issue_long = is_long;
      issue_rs1_address = rs1; issue_rs2_address = rs2; issue_rd_address = rd;
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clock) begin
      if (rf_write_enable === 1'b1) begin
         compared++;
         if (expected_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                     rf_rd_address, rf_write_data);
         end else begin
            logic [36:0] exp_entry;
            exp_entry = expected_q.pop_front();
            if ({rf_rd_address, rf_write_data} !== exp_entry) begin
               mismatched++;
               $display("FAIL writeback: got rd=%0d data=%h, expected rd=%0d data=%h",
                        rf_rd_address, rf_write_data, exp_entry[36:32], exp_entry[31:0]);
            end
         end
      end
   end

   initial begin
      reset = 1;
      clear_inputs();
      #1;
      check("reset_we", rf_write_enable, 0);
      check("reset_busy", busy_map, 0);
      check("reset_outstanding", dut.u_scoreboard.outstanding_q, 0);
      short_valid = 1; long_valid = 1;
      #1;
      check("reset_short_ready", short_ready, 1);
      check("reset_long_ready_blocked", long_ready, 0);
      short_valid = 0;
      #1;
      check("reset_long_ready", long_ready, 1);
      clear_inputs();
      @(negedge clock);
      reset = 0;
      step();

      // Short only
      short_valid = 1; short_rd_address = 5; short_data = 32'hDEADBEEF;
      #1;
      check("short_ready", short_ready, 1);
      check("short_only_long_ready", long_ready, 0);
      expected_q.push_back({5'd5, 32'hDEADBEEF});
      step();
      clear_inputs();
      step();

      // Contention: short wins three cycles, then long is forced through
      for (int c = 1; c <= 4; c++) begin
         short_valid = 1; short_rd_address = 10; short_data = 32'hA000_0000 + c;
         long_valid = 1; long_rd_address = 11; long_data = 32'hB000_0001;
         #1;
         check($sformatf("contend_short_ready_c%0d", c), short_ready, (c < 4) ? 1 : 0);
         check($sformatf("contend_long_ready_c%0d", c), long_ready, (c == 4) ? 1 : 0);
         if (c < 4) expected_q.push_back({5'd10, 32'hA000_0000 + c});
         else       expected_q.push_back({5'd11, 32'hB000_0001});
         step();
      end
      short_data = 32'hA000_0005;
      #1;
      check("starve_cleared_short_ready", short_ready, 1);
      check("starve_cleared_long_ready", long_ready, 0);
      expected_q.push_back({5'd10, 32'hA000_0005});
      step();
      clear_inputs();
      step();

      // Scoreboard hazard on rd = 7
      issue(1, 0, 0, 7);
      #1;
      check("sb_long_issue_stall", issue_stall, 0);
      step();
      issue(0, 7, 0, 8);
      #1;
      check("sb_busy_set", busy_map, 32'h0000_0080);
      check("sb_rs1_stall", issue_stall, 1);
      step();
      long_valid = 1; long_rd_address = 7; long_data = 32'h0000_C0DE;
      #1;
      check("sb_no_bypass_stall", issue_stall, 1);
      check("sb_long_ready", long_ready, 1);
      expected_q.push_back({5'd7, 32'h0000_C0DE});
      step();
      long_valid = 0;
      #1;
      check("sb_busy_cleared", busy_map, 0);
      check("sb_stall_released", issue_stall, 0);
      step();
      clear_inputs();
      step();

      // x0 destination
      issue(1, 0, 0, 0);
      #1;
      check("x0_issue_stall", issue_stall, 0);
      step();
      clear_inputs();
      #1;
      check("x0_busy_unchanged", busy_map, 0);
      check("x0_outstanding_inc", dut.u_scoreboard.outstanding_q, 1);
      long_valid = 1; long_rd_address = 0; long_data = 32'h0000_1234;
      #1;
      check("x0_long_ready", long_ready, 1);
      step();
      clear_inputs();
      #1;
      check("x0_no_write", rf_write_enable, 0);
      check("x0_outstanding_zero", dut.u_scoreboard.outstanding_q, 0);
      step();

      // Full: four long ops outstanding
      for (int i = 1; i <= 4; i++) begin
         issue(1, 0, 0, 5'(i));
         #1;
         check($sformatf("full_issue_%0d_stall", i), issue_stall, 0);
         step();
      end
      issue(1, 0, 0, 5);
      #1;
      check("full_fifth_stall", issue_stall, 1);
      check("full_busy", busy_map, 32'h0000_001E);
      check("full_outstanding", dut.u_scoreboard.outstanding_q, 4);
      step();
      long_valid = 1; long_rd_address = 2; long_data = 32'h0000_2222;
      #1;
      check("full_stall_with_retire", issue_stall, 1);
      check("full_long_ready", long_ready, 1);
      expected_q.push_back({5'd2, 32'h0000_2222});
      step();
      long_valid = 0;
      #1;
      check("full_fifth_released", issue_stall, 0);
      check("full_busy_after_retire", busy_map, 32'h0000_001A);
      step();
      clear_inputs();
      #1;
      check("full_outstanding_after", dut.u_scoreboard.outstanding_q, 4);
      check("full_busy_after_issue", busy_map, 32'h0000_003A);

      // Drain, then build busy_map = 6 / outstanding = 2
      begin
         logic [4:0] drain_rd[4];
         drain_rd = '{5'd1, 5'd3, 5'd4, 5'd5};
         for (int i = 0; i < 4; i++) begin
            long_valid = 1; long_rd_address = drain_rd[i]; long_data = 32'h5000_0000 + i;
            #1;
            check($sformatf("drain_%0d_long_ready", i), long_ready, 1);
            expected_q.push_back({drain_rd[i], 32'h5000_0000 + i});
            step();
         end
      end
      clear_inputs();
      #1;
      check("drain_busy", busy_map, 0);
      issue(1, 0, 0, 1);
      step();
      issue(1, 0, 0, 2);
      step();
      clear_inputs();
      #1;
      check("pre_reset_busy", busy_map, 32'h0000_0006);
      check("pre_reset_outstanding", dut.u_scoreboard.outstanding_q, 2);

      // Reset mid-operation with a write strobe pending
      short_valid = 1; short_rd_address = 9; short_data = 32'h0000_0099;
      @(posedge clock);
      #2;
      reset = 1;
      #1;
      check("midreset_busy", busy_map, 0);
      check("midreset_outstanding", dut.u_scoreboard.outstanding_q, 0);
      check("midreset_we", rf_write_enable, 0);
      clear_inputs();
      @(negedge clock);
      reset = 0;
      step();
      step();
      check("post_reset_we", rf_write_enable, 0);
      check("post_reset_busy", busy_map, 0);
      check("pending_writes_left", expected_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_writeback_scheduler.md
REGFILE_WRITEBACK_SCHEDULER -- requirements
Module: regfile_writeback_scheduler

Interface
REQ-001 The block SHALL have these parameters: LONG_MAX = 4, the maximum outstanding long-latency ops; STARVE_LIMIT = 3, the consecutive lost cycles before long gets forced priority.
REQ-002 The block SHALL have these ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode presenting an instruction
- issue_long  in  1  instruction's result comes from the long-latency unit
- issue_rs1_address, issue_rs2_address, issue_rd_address  in  5 each  instruction operands
- issue_stall  out  1  hold decode; the instruction is not issued
- short_valid  in  1  single-cycle execute result available
- short_rd_address  in  5
- short_data  in  32
- short_ready  out  1  short result accepted this cycle
- long_valid  in  1  long-latency result available
- long_rd_address  in  5
- long_data  in  32
- long_ready  out  1  long result accepted this cycle
- rf_rd_address  out  5  register file write address
- rf_write_data  out  32  register file write data
- rf_write_enable  out  1  register file write strobe
- busy_map  out  32  pending long-latency destinations

Function
REQ-003 A result SHALL be accepted when valid && ready are high on a rising clock edge.
REQ-004 The block SHALL accept at most one result per cycle.
REQ-005 Arbitration SHALL be:
- short_ready = short_valid && !force_long.
- long_ready = long_valid && (!short_valid || force_long).
REQ-006 The starvation counter SHALL behave as follows:
- Increments when long_valid && !long_ready.
- Clears on any long acceptance, or when long_valid is low.
- Saturates at STARVE_LIMIT.
- force_long = (counter == STARVE_LIMIT).
REQ-007 Write-back outputs SHALL be registered, with 1-cycle latency:
- The edge that accepts a result loads rf_rd_address/rf_write_data with that result's address/data.
- On that edge, rf_write_enable is set to (rd_address != 0).
- With no acceptance, rf_write_enable = 0 and the address/data registers hold their values.
REQ-008 Writes to x0 SHALL still complete the handshake and SHALL NOT assert rf_write_enable.
REQ-009 The scoreboard SHALL track pending long destinations as follows:
- busy_map bit n is set on the edge where an issue is accepted with issue_long = 1 and rd = n, n != 0.
- Bit n is cleared on the edge where a long result with rd = n is accepted.
- If set and clear for the same n occur in one cycle, set wins.
- busy_map[0] is always 0.
REQ-010 Issue acceptance SHALL be defined as issue_valid && !issue_stall.
REQ-011 issue_stall SHALL be combinational and asserted when issue_valid and any of the following holds (x0 operands never stall):
- busy_map[rs1] is set.
- busy_map[rs2] is set.
- busy_map[rd] is set.
- issue_long && outstanding == LONG_MAX.
REQ-012 There SHALL be no bypass: a busy register being written back in the same cycle still stalls; the stall releases the cycle after.
REQ-013 The outstanding counter (3 bits) SHALL track long ops:
- Increments on an accepted long issue.
- Decrements on long acceptance.
- Both in the same cycle leaves it unchanged.
- It never exceeds LONG_MAX or wraps below 0.
REQ-014 A long acceptance while outstanding == 0 SHALL be a protocol error: the write is still performed and the counter stays 0.

Reset
REQ-015 Reset SHALL asynchronously clear the starvation counter, outstanding counter, busy_map, rf_rd_address, rf_write_data and rf_write_enable to 0.
REQ-016 During reset, short_ready and long_ready SHALL follow REQ-005, with force_long = 0.
REQ-017 Reset asserted mid-operation SHALL discard all pending scoreboard state; no write is issued after reset deasserts until a new acceptance occurs.

Structure
REQ-018 A shared package SHALL hold the WritebackRequest struct (rd_address[4:0], data[31:0]) and the constants LONG_MAX and STARVE_LIMIT.
REQ-019 The busy_map, the outstanding counter and the stall logic SHALL be a sub-module named register_scoreboard; arbitration and the output register stay in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Short only: short_valid, rd = 5, data = 32'hDEADBEEF → short_ready = 1; next cycle rf_write_enable = 1, rf_rd_address = 5, rf_write_data = 32'hDEADBEEF.
- Contention: short_valid and long_valid held 4 cycles → short wins cycles 1-3; long_ready = 1 in cycle 4; counter then clears.
- Scoreboard: long issue rd = 7; next cycle an issue with rs1 = 7 → issue_stall = 1 until the cycle after long rd = 7 is accepted; busy_map[7] goes 1 then 0.
- x0: long issue rd = 0 → busy_map unchanged, outstanding increments; long result rd = 0 accepted → rf_write_enable = 0, outstanding returns to 0.
- Full: 4 long issues to rd = 1..4 → a 5th long issue stalls; accepting long rd = 2 with the 5th issue in the same cycle → the 5th issues next cycle, outstanding stays 4.
- Reset mid-op: busy_map = 32'h0000_0006 and outstanding = 2, assert reset → busy_map = 0, outstanding = 0, rf_write_enable = 0 immediately, with no clock edge.
